ps2_scan_rx: RTL and testbench
==============================

Name: ps2_scan_rx

Overview:
- PS/2 keyboard receiver feeding the scan-code validation stage that decodes the 1/2/3, p/c, b/n, q and Enter keys.
- Synchronises and deglitches the PS/2 clock and data lines, deframes 11-bit frames and checks parity.
- Strips break (F0) and extended (E0) sequences, so downstream sees only non-extended make codes.
- `scan_code` drives the validation stage's `datain` directly; `code_rdy` tells the downstream control FSM when a fresh key press occurred.

Parameters:
- FILTER_LEN, 4: consecutive clk cycles a synchronised ps2c level must hold before the filtered clock follows it.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2c falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ps2c  in  1  raw PS/2 clock, asynchronous, idle high.
- ps2d  in  1  raw PS/2 data, asynchronous, idle high.
- scan_code  out  8  last accepted make code; 8'h00 when no key is held.
- code_rdy  out  1  one-cycle pulse: scan_code just loaded with a new make code.
- key_rel  out  1  one-cycle pulse: break sequence for a non-extended key completed.
- frame_err  out  1  one-cycle pulse: parity error, bad stop bit, or timeout abort.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: scan_code=8'h00; code_rdy, key_rel, frame_err=0.
  - Internals: FSM=IDLE, bit counter=0, brk_pend=0, ext_pend=0, filtered clock=1, sync flops=1, timeout counter=0.
  - Reset asserted mid-frame discards the partial frame; nothing is emitted.
- Input conditioning:
  - ps2c and ps2d each pass through a 2-flop synchroniser.
  - The filtered clock takes the synchronised ps2c value only after FILTER_LEN equal consecutive samples; shorter glitches are ignored.
  - fall = filtered clock 1->0 (single-cycle strobe). ps2d is sampled (synchronised value) in the fall cycle.
- Deframing FSM, advancing only on fall:
  - IDLE: data=0 -> DATA with cnt=0; data=1 (false start) -> stay IDLE, no error.
  - DATA: shift data in LSB-first; after the 8th bit -> PAR.
  - PAR: capture the parity bit -> STOP.
  - STOP: -> IDLE and evaluate the frame. The frame is good when stop=1 and the 8 data bits plus parity have odd weight. Otherwise pulse frame_err in the next cycle and clear brk_pend and ext_pend.
  - Timeout: in DATA, PAR or STOP, the counter increments each clk and clears on fall. Reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, brk_pend and ext_pend cleared. The counter is held at 0 in IDLE.
- Code layer, acting on each good byte B in the cycle after the STOP fall (latency: 1 clk from the stop-bit fall to the outputs):
  - B=E0: set ext_pend; no output.
  - B=F0: set brk_pend; no output.
  - Otherwise, by pending flags:
    - ext_pend=1: discard B and clear both flags (extended keys are never forwarded).
    - brk_pend=1, ext_pend=0: clear brk_pend, pulse key_rel; scan_code<=8'h00 only if B equals the current scan_code, else scan_code is unchanged.
    - Neither flag set: scan_code<=B, code_rdy=1 for one cycle. Typematic repeats of the same code re-pulse code_rdy.
- Pulses are never stretched. code_rdy and key_rel cannot coincide; frame_err excludes both in the same cycle.
- scan_code changes only as stated above; it is stable otherwise.

Test Plan:
- Frame 0x16 (parity 0, stop 1) at a 12.5 kHz PS/2 clock -> scan_code=8'h16; code_rdy high exactly 1 clk; key_rel and frame_err stay 0.
- Frames 0x5A, F0, 5A -> code_rdy once (scan_code=8'h5A), then key_rel once, scan_code=8'h00; no code_rdy for the break byte.
- Frame 0x32 with parity flipped -> frame_err 1 clk; scan_code keeps its previous value (8'h00 after reset); a following clean 0x31 yields scan_code=8'h31 with code_rdy.
- E0 75, then E0 F0 75 -> no code_rdy, no key_rel, scan_code unchanged; a following 0x1E yields scan_code=8'h1E.
- Start bit plus 4 data bits, then ps2c held high -> frame_err exactly TIMEOUT_CYCLES clk after the last fall; a following clean 0x26 decodes to scan_code=8'h26.
- 2-clk low glitch on ps2c while idle is ignored (no state change).
- rst_n pulsed low mid-frame -> all outputs 0 immediately, no pulses; the next clean 0x4D decodes to scan_code=8'h4D.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches ps2c/ps2d, deframes 11-bit frames, strips F0/E0 sequences.
// Latency: 1 clk from the stop-bit filtered fall to the outputs. No backpressure; every output is a pulse or a held level.
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] scan_code,
  output logic       code_rdy,
  output logic       key_rel,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  logic          r_c_meta, r_c_sync, r_d_meta, r_d_sync;
  logic          r_filt, r_filt_q;
  logic [FW-1:0] r_fcnt;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic          r_brk_pend, r_ext_pend;
  logic [7:0]    r_scan_code;
  logic          r_code_rdy, r_key_rel, r_frame_err;

  logic          w_fall;
  logic          w_good;
  logic          w_timeout;

  // Filtered clock only follows the synchronised line after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_meta <= 1'b1;
      r_c_sync <= 1'b1;
      r_d_meta <= 1'b1;
      r_d_sync <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_q <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_c_meta <= ps2c;
      r_c_sync <= r_c_meta;
      r_d_meta <= ps2d;
      r_d_sync <= r_d_meta;
      r_filt_q <= r_filt;
      if (r_c_sync == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= r_c_sync;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_fall    = r_filt_q & ~r_filt;
  assign w_good    = r_d_sync & (^{r_shift, r_par});
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_tcnt      <= '0;
      r_brk_pend  <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_scan_code <= 8'h00;
      r_code_rdy  <= 1'b0;
      r_key_rel   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_code_rdy  <= 1'b0;
      r_key_rel   <= 1'b0;
      r_frame_err <= 1'b0;

      if (r_state == S_IDLE || w_fall) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      if (w_timeout) begin
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
        r_brk_pend  <= 1'b0;
        r_ext_pend  <= 1'b0;
      end else if (w_fall) begin
        unique case (r_state)
          S_IDLE: begin
            if (!r_d_sync) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {r_d_sync, r_shift[7:1]};
            if (r_cnt == 3'd7) begin
              r_state <= S_PAR;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_PAR: begin
            r_par   <= r_d_sync;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!w_good) begin
              r_frame_err <= 1'b1;
              r_brk_pend  <= 1'b0;
              r_ext_pend  <= 1'b0;
            end else if (r_shift == 8'hE0) begin
              r_ext_pend <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_brk_pend <= 1'b1;
            end else if (r_ext_pend) begin
              // Extended keys are swallowed whole, make or break.
              r_ext_pend <= 1'b0;
              r_brk_pend <= 1'b0;
            end else if (r_brk_pend) begin
              r_brk_pend <= 1'b0;
              r_key_rel  <= 1'b1;
              if (r_shift == r_scan_code) begin
                r_scan_code <= 8'h00;
              end
            end else begin
              r_scan_code <= r_shift;
              r_code_rdy  <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign scan_code = r_scan_code;
  assign code_rdy  = r_code_rdy;
  assign key_rel   = r_key_rel;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: expected output events are queued as frames are driven and popped as pulses appear.
module tb_ps2_scan_rx;

  localparam int FILT  = 4;
  localparam int TOUT  = 5000;
  localparam int SLOW  = 2000;  // half-period of a 12.5 kHz PS/2 clock at 50 MHz
  localparam int FAST  = 25;
  // Raw ps2c fall to internal fall acting: 2 sync flops + FILT filter samples + 1 edge detect.
  localparam int LAT   = 2 + FILT + 1;

  localparam logic [1:0] EV_CODE = 2'd1;
  localparam logic [1:0] EV_REL  = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] code;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       ps2c;
  logic       ps2d;
  logic [7:0] scan_code;
  logic       code_rdy;
  logic       key_rel;
  logic       frame_err;

  int  n_checks = 0;
  int  n_fail   = 0;
  ev_t exp_q[$];
  bit  done = 0;

  ps2_scan_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .scan_code (scan_code),
    .code_rdy  (code_rdy),
    .key_rel   (key_rel),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int half);
    ps2d = b;
    clk_wait(half);
    ps2c = 1'b0;
    clk_wait(half);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input int half);
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit((~^b) ^ flip, half);
    send_bit(1'b1, half);
    ps2d = 1'b1;
    clk_wait(2 * half);
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] code);
    ev_t e;
    e.kind = kind;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // Output monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!done && rst_n && (code_rdy || key_rel || frame_err)) begin
      ev_t        e;
      logic [1:0] got_kind;
      got_kind = code_rdy ? EV_CODE : (key_rel ? EV_REL : EV_ERR);
      check_eq("pulse_exclusive", 32'(int'(code_rdy) + int'(key_rel) + int'(frame_err)), 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {30'd0, got_kind}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("event_kind", {30'd0, got_kind}, {30'd0, e.kind});
        check_eq("event_scan_code", {24'd0, scan_code}, {24'd0, e.code});
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    clk_wait(3);
    check_eq("rst_scan_code", {24'd0, scan_code}, 32'h00);
    check_eq("rst_code_rdy", {31'd0, code_rdy}, 32'd0);
    check_eq("rst_key_rel", {31'd0, key_rel}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    clk_wait(10);

    push(EV_CODE, 8'h16);
    send_frame(8'h16, 1'b0, SLOW);

    push(EV_CODE, 8'h5A);
    send_frame(8'h5A, 1'b0, FAST);
    send_frame(8'hF0, 1'b0, FAST);
    push(EV_REL, 8'h00);
    send_frame(8'h5A, 1'b0, FAST);
    check_eq("after_break", {24'd0, scan_code}, 32'h00);

    push(EV_ERR, 8'h00);
    send_frame(8'h32, 1'b1, FAST);
    push(EV_CODE, 8'h31);
    send_frame(8'h31, 1'b0, FAST);

    send_frame(8'hE0, 1'b0, FAST);
    send_frame(8'h75, 1'b0, FAST);
    send_frame(8'hE0, 1'b0, FAST);
    send_frame(8'hF0, 1'b0, FAST);
    send_frame(8'h75, 1'b0, FAST);
    check_eq("after_extended", {24'd0, scan_code}, 32'h31);
    push(EV_CODE, 8'h1E);
    send_frame(8'h1E, 1'b0, FAST);

    // Break for a key other than the held one releases but keeps scan_code.
    send_frame(8'hF0, 1'b0, FAST);
    push(EV_REL, 8'h1E);
    send_frame(8'h16, 1'b0, FAST);

    // Partial frame then silence: timeout measured from the last raw fall.
    push(EV_ERR, 8'h1E);
    send_bit(1'b0, FAST);
    for (int i = 0; i < 3; i++) send_bit(1'b1, FAST);
    ps2d = 1'b0;
    clk_wait(FAST);
    ps2c = 1'b0;
    n = 0;
    while (!frame_err && n < TOUT + LAT + 100) begin
      clk_wait(1);
      n++;
      if (n == FAST) ps2c = 1'b1;
    end
    ps2d = 1'b1;
    check_eq("timeout_latency", n, TOUT + LAT);
    clk_wait(20);
    push(EV_CODE, 8'h26);
    send_frame(8'h26, 1'b0, FAST);

    // Short low glitch on ps2c with data low must not start a frame.
    ps2d = 1'b0;
    ps2c = 1'b0;
    clk_wait(2);
    ps2c = 1'b1;
    clk_wait(10);
    ps2d = 1'b1;
    clk_wait(20);
    push(EV_CODE, 8'h1C);
    send_frame(8'h1C, 1'b0, FAST);

    send_bit(1'b0, FAST);
    for (int i = 0; i < 3; i++) send_bit(1'b1, FAST);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_scan_code", {24'd0, scan_code}, 32'h00);
    check_eq("midrst_code_rdy", {31'd0, code_rdy}, 32'd0);
    check_eq("midrst_key_rel", {31'd0, key_rel}, 32'd0);
    check_eq("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    ps2c = 1'b1;
    ps2d = 1'b1;
    clk_wait(5);
    rst_n = 1'b1;
    clk_wait(10);
    push(EV_CODE, 8'h4D);
    send_frame(8'h4D, 1'b0, FAST);

    clk_wait(50);
    check_eq("final_scan_code", {24'd0, scan_code}, 32'h4D);
    check_eq("pending_events", exp_q.size(), 32'd0);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
